// File: rtl/lcd_page_mapper_if.sv
// Character request/response channel between the LCD write sequencer (master)
// and the page mapper (slave).
interface lcd_page_mapper_if #(
  parameter int IDX_W = 5
);
  logic [IDX_W-1:0] index;
  logic             index_valid;
  logic [7:0]       out;
  logic             out_valid;

  modport master (
    output index,
    output index_valid,
    input  out,
    input  out_valid
  );

  modport slave (
    input  index,
    input  index_valid,
    output out,
    output out_valid
  );
endinterface

// File: rtl/lcd_page_mapper.sv
// Renders one LCD character cell per request for the DATE/TIME and ALARM pages,
// with a blinking edit-field cursor, a page toggle and an inactivity timeout.
//
// state | meaning
// IDLE  | no field selected; sw_page toggles the page, divider parked at 0
// EDIT  | field edit_field selected; divider runs, selected field blinks
module lcd_page_mapper #(
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int BLINK_DIV    = 25_000_000,
  parameter int EDIT_TIMEOUT = 20,
  localparam int IDX_W       = $clog2(ROWS * COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_edit,
  input  logic                    sw_page,
  input  logic [27:0]             date_bcd,
  input  logic [23:0]             time_bcd,
  input  logic [15:0]             alarm_bcd,
  input  logic                    alarm_en,
  lcd_page_mapper_if.slave        bus,
  output logic                    page,
  output logic [2:0]              edit_field
);

  localparam int DIV_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int TMO_W = $clog2(EDIT_TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EDIT_TIMEOUT - 1);

  localparam logic [31:0] COLS_U  = 32'(COLS);
  localparam logic [31:0] CELLS_U = 32'(ROWS * COLS);

  // Row templates hold the fixed labels and separators; digit cells are overridden.
  localparam logic [127:0] P0R0     = "DATE 2YYY/MM/DD ";
  localparam logic [127:0] P0R1     = "TIME   :  :     ";
  localparam logic [127:0] P1R0     = "ALARM   :       ";
  localparam logic [127:0] P1R1_ON  = "ALM ON          ";
  localparam logic [127:0] P1R1_OFF = "ALM OFF         ";

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       field_q, field_d;
  logic             page_q, page_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       nf;

  function automatic logic [7:0] dig(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : {4'h3, n};
  endfunction

  // ---------------------------------------------------------------- edit FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      field_q <= 3'd0;
      page_q  <= 1'b0;
      div_q   <= '0;
      phase_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      page_q  <= page_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    page_d  = page_q;
    div_d   = div_q;
    phase_d = phase_q;
    tmo_d   = tmo_q;
    nf      = page_q ? 3'd3 : 3'd6;

    unique case (state_q)
      IDLE: begin
        if (sw_edit) begin
          state_d = EDIT;
          field_d = 3'd1;
          div_d   = '0;
          phase_d = 1'b0;
          tmo_d   = '0;
        end else if (sw_page) begin
          page_d = ~page_q;
        end
      end

      EDIT: begin
        if (sw_edit) begin
          div_d   = '0;
          phase_d = 1'b0;
          tmo_d   = '0;
          if (field_q == nf) begin
            state_d = IDLE;
            field_d = 3'd0;
          end else begin
            field_d = field_q + 3'd1;
          end
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          // The toggle that would complete the timeout instead abandons edit mode.
          if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            field_d = 3'd0;
            phase_d = 1'b0;
            tmo_d   = '0;
          end else begin
            phase_d = ~phase_q;
            tmo_d   = tmo_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        field_d = 3'd0;
      end
    endcase
  end

  assign page       = page_q;
  assign edit_field = field_q;

  // ---------------------------------------------------------------- cell decode
  logic [31:0]  idx_w, row_w, col_w;
  logic [3:0]   col_lo;
  logic         row_lo;
  logic         cell_on;
  logic [127:0] tmpl;
  logic [3:0]   nib;
  logic         dig_en;
  logic [2:0]   cell_fld;
  logic [7:0]   out_d;

  assign idx_w   = 32'(bus.index);
  assign row_w   = idx_w / COLS_U;
  assign col_w   = idx_w % COLS_U;
  assign col_lo  = col_w[3:0];
  assign row_lo  = row_w[0];
  assign cell_on = (idx_w < CELLS_U) && (row_w < 32'd2) && (col_w < 32'd16);

  always_comb begin
    tmpl     = P0R0;
    nib      = 4'd0;
    dig_en   = 1'b0;
    cell_fld = 3'd0;

    unique case ({page_q, row_lo})
      2'b00: begin
        tmpl = P0R0;
        unique case (col_lo)
          4'd6:    begin nib = date_bcd[27:24]; dig_en = 1'b1; cell_fld = 3'd1; end
          4'd7:    begin nib = date_bcd[23:20]; dig_en = 1'b1; cell_fld = 3'd1; end
          4'd8:    begin nib = date_bcd[19:16]; dig_en = 1'b1; cell_fld = 3'd1; end
          4'd10:   begin nib = date_bcd[15:12]; dig_en = 1'b1; cell_fld = 3'd2; end
          4'd11:   begin nib = date_bcd[11:8];  dig_en = 1'b1; cell_fld = 3'd2; end
          4'd13:   begin nib = date_bcd[7:4];   dig_en = 1'b1; cell_fld = 3'd3; end
          4'd14:   begin nib = date_bcd[3:0];   dig_en = 1'b1; cell_fld = 3'd3; end
          default: ;
        endcase
      end

      2'b01: begin
        tmpl = P0R1;
        unique case (col_lo)
          4'd5:    begin nib = time_bcd[23:20]; dig_en = 1'b1; cell_fld = 3'd4; end
          4'd6:    begin nib = time_bcd[19:16]; dig_en = 1'b1; cell_fld = 3'd4; end
          4'd8:    begin nib = time_bcd[15:12]; dig_en = 1'b1; cell_fld = 3'd5; end
          4'd9:    begin nib = time_bcd[11:8];  dig_en = 1'b1; cell_fld = 3'd5; end
          4'd11:   begin nib = time_bcd[7:4];   dig_en = 1'b1; cell_fld = 3'd6; end
          4'd12:   begin nib = time_bcd[3:0];   dig_en = 1'b1; cell_fld = 3'd6; end
          default: ;
        endcase
      end

      2'b10: begin
        tmpl = P1R0;
        unique case (col_lo)
          4'd6:    begin nib = alarm_bcd[15:12]; dig_en = 1'b1; cell_fld = 3'd1; end
          4'd7:    begin nib = alarm_bcd[11:8];  dig_en = 1'b1; cell_fld = 3'd1; end
          4'd9:    begin nib = alarm_bcd[7:4];   dig_en = 1'b1; cell_fld = 3'd2; end
          4'd10:   begin nib = alarm_bcd[3:0];   dig_en = 1'b1; cell_fld = 3'd2; end
          default: ;
        endcase
      end

      default: begin
        tmpl = alarm_en ? P1R1_ON : P1R1_OFF;
        if (col_lo >= 4'd4 && col_lo <= 4'd6) cell_fld = 3'd3;
      end
    endcase

    if (!cell_on)
      out_d = 8'h20;
    else if (phase_q && (cell_fld != 3'd0) && (cell_fld == field_q))
      out_d = 8'h20;
    else if (dig_en)
      out_d = dig(nib);
    else
      out_d = tmpl[{~col_lo, 3'b000} +: 8];
  end

  // ---------------------------------------------------------------- response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out       <= 8'h00;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.index_valid;
      if (bus.index_valid) bus.out <= out_d;
    end
  end

endmodule

// File: tb/tb_lcd_page_mapper.sv
// Directed bench for lcd_page_mapper: page scans, digit/blank boundaries,
// blink timing, edit timeout and asynchronous reset.
module tb_lcd_page_mapper;

  localparam int COLS  = 16;
  localparam int ROWS  = 3;
  localparam int IDX_W = $clog2(ROWS * COLS);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sw_edit, sw_page, alarm_en;
  logic [27:0] date_bcd;
  logic [23:0] time_bcd;
  logic [15:0] alarm_bcd;
  logic        page;
  logic [2:0]  edit_field;

  int n_cmp = 0;
  int n_err = 0;

  lcd_page_mapper_if #(.IDX_W(IDX_W)) bus ();

  lcd_page_mapper #(
    .COLS(COLS), .ROWS(ROWS), .BLINK_DIV(4), .EDIT_TIMEOUT(3)
  ) dut (
    .clk(clk), .rst(rst), .sw_edit(sw_edit), .sw_page(sw_page),
    .date_bcd(date_bcd), .time_bcd(time_bcd), .alarm_bcd(alarm_bcd),
    .alarm_en(alarm_en), .bus(bus), .page(page), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int idx, input string tag, input logic [7:0] exp);
    bus.index       = IDX_W'(idx);
    bus.index_valid = 1'b1;
    step();
    chk_val($sformatf("%s idx%0d", tag, idx), {24'd0, bus.out}, {24'd0, exp});
    chk_val($sformatf("%s vld%0d", tag, idx), {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic scan(input string r0, input string r1, input string tag);
    for (int i = 0; i < 32; i++)
      req(i, tag, (i < 16) ? r0[i] : r1[i - 16]);
  endtask

  task automatic pulse_page();
    sw_page = 1'b1;
    step();
    sw_page = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp;
    sw_edit = 1'b0; sw_page = 1'b0; alarm_en = 1'b0;
    date_bcd = 28'h0240615; time_bcd = 24'h130509; alarm_bcd = 16'h0730;
    bus.index = '0; bus.index_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_val("rst out",   {24'd0, bus.out},       32'h00);
    chk_val("rst vld",   {31'd0, bus.out_valid}, 32'd0);
    chk_val("rst page",  {31'd0, page},          32'd0);
    chk_val("rst field", {29'd0, edit_field},    32'd0);
    rst = 1'b1;
    step();

    // page 0 full scan and gap
    scan("DATE 2024/06/15 ", "TIME 13:05:09   ", "p0");
    bus.index_valid = 1'b0;
    step();
    chk_val("gap vld",  {31'd0, bus.out_valid}, 32'd0);
    chk_val("gap hold", {24'd0, bus.out},       32'h20);

    // bad nibble, out-of-range cells, live inputs
    date_bcd = 28'h024C615;
    req(10, "badnib", 8'h3F);
    req(11, "nibnext", "6");
    req(40, "row2", 8'h20);
    req(63, "oor", 8'h20);
    time_bcd = 24'h230509;
    req(21, "live", "2");
    date_bcd = 28'h0240615;
    time_bcd = 24'h130509;
    bus.index_valid = 1'b0;

    // page 1
    pulse_page();
    chk_val("page1", {31'd0, page}, 32'd1);
    scan("ALARM 07:30     ", "ALM OFF         ", "p1");
    alarm_en = 1'b1;
    req(20, "en", "O");
    req(21, "en", "N");
    req(22, "en", " ");
    bus.index_valid = 1'b0;

    // blink of hour field, then timeout without presses
    pulse_page();
    chk_val("page0", {31'd0, page}, 32'd0);
    sw_edit = 1'b1;
    repeat (4) step();
    sw_edit = 1'b0;
    chk_val("field4", {29'd0, edit_field}, 32'd4);
    bus.index = IDX_W'(21);
    bus.index_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = (k >= 5 && k <= 8) ? 8'h20 : "1";
      chk_val($sformatf("blink k%0d", k), {24'd0, bus.out}, {24'd0, exp});
      if (k == 11) chk_val("tmo k11", {29'd0, edit_field}, 32'd4);
      if (k == 12) chk_val("tmo k12", {29'd0, edit_field}, 32'd0);
    end

    // year field: label '2' never blanked; press at cycle 10 restarts timeout
    sw_edit = 1'b1;
    step();
    sw_edit = 1'b0;
    chk_val("field1", {29'd0, edit_field}, 32'd1);
    for (int k = 1; k <= 9; k++) begin
      bus.index = IDX_W'((k % 2 == 1) ? 7 : 5);
      step();
      exp = ((k % 2 == 1) && k >= 5 && k <= 8) ? 8'h20 : "2";
      chk_val($sformatf("year k%0d", k), {24'd0, bus.out}, {24'd0, exp});
    end
    sw_edit = 1'b1;
    bus.index = IDX_W'(10);
    step();
    sw_edit = 1'b0;
    chk_val("field2", {29'd0, edit_field}, 32'd2);
    chk_val("mon k10", {24'd0, bus.out}, 32'h30);
    for (int k = 1; k <= 12; k++) begin
      bus.index = IDX_W'((k % 2 == 1) ? 10 : 12);
      step();
      if (k % 2 == 1) exp = (k >= 5 && k <= 8) ? 8'h20 : "0";
      else            exp = "/";
      chk_val($sformatf("mon k%0d", k), {24'd0, bus.out}, {24'd0, exp});
      if (k == 11) chk_val("rst-tmo k11", {29'd0, edit_field}, 32'd2);
      if (k == 12) chk_val("rst-tmo k12", {29'd0, edit_field}, 32'd0);
    end
    bus.index_valid = 1'b0;

    // simultaneous presses, field wrap on both pages, page ignored in edit
    sw_edit = 1'b1; sw_page = 1'b1;
    step();
    sw_page = 1'b0;
    chk_val("both field", {29'd0, edit_field}, 32'd1);
    chk_val("both page",  {31'd0, page},       32'd0);
    repeat (5) step();
    sw_edit = 1'b0;
    chk_val("nf6", {29'd0, edit_field}, 32'd6);
    sw_edit = 1'b1;
    step();
    sw_edit = 1'b0;
    chk_val("wrap6", {29'd0, edit_field}, 32'd0);
    pulse_page();
    chk_val("page1b", {31'd0, page}, 32'd1);
    sw_edit = 1'b1;
    repeat (3) step();
    sw_edit = 1'b0;
    chk_val("nf3", {29'd0, edit_field}, 32'd3);
    pulse_page();
    chk_val("page ign", {31'd0, page}, 32'd1);
    sw_edit = 1'b1;
    step();
    chk_val("wrap3", {29'd0, edit_field}, 32'd0);
    step();
    sw_edit = 1'b0;
    chk_val("re-edit", {29'd0, edit_field}, 32'd1);

    // asynchronous reset mid-edit
    req(0, "pre-rst", "A");
    #2;
    rst = 1'b0;
    #1;
    chk_val("arst out",   {24'd0, bus.out},       32'h00);
    chk_val("arst vld",   {31'd0, bus.out_valid}, 32'd0);
    chk_val("arst page",  {31'd0, page},          32'd0);
    chk_val("arst field", {29'd0, edit_field},    32'd0);
    bus.index_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk_val("post vld", {31'd0, bus.out_valid}, 32'd0);
    chk_val("post out", {24'd0, bus.out},       32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
